servo_pwm_gen: RTL and testbench
================================

SERVO_PWM_GEN -- requirements
Module: servo_pwm_gen

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz; SHALL be an integer multiple of 1000000.
REQ-002 Parameter PERIOD_US, default 20000, PWM frame length in microseconds.
REQ-003 Parameter MIN_US, default 1000, pulse width for angle 0.
REQ-004 Parameter MAX_US, default 2000, pulse width for angle 180.
REQ-005 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 en  input  1  output enable; low forces all PWM outputs low.
REQ-008 angle1..angle4  input  8 each  requested servo angle in degrees, nominal range 0..180.
REQ-009 pwm1..pwm4  output  1 each  registered servo drive pulses.
REQ-010 frame_start  output  1  registered one-cycle pulse marking each frame start.

Function
REQ-011 Prescaler SHALL count 0..CLK_HZ/1000000-1 and wrap; its terminal value SHALL be the microsecond tick.
REQ-012 us_cnt SHALL increment on each microsecond tick and wrap from PERIOD_US-1 to 0.
REQ-013 Frame boundary SHALL be the edge on which the tick occurs with us_cnt = PERIOD_US-1.
REQ-014 On each frame boundary, four shadow width registers SHALL load width_i = MIN_US + (angle_i * (MAX_US-MIN_US)) / 180, integer truncation, ≥20-bit intermediate; no other edge SHALL modify them.
REQ-015 Angle changes between boundaries SHALL NOT affect the current frame; latency from angle change to effect is up to one frame.
REQ-016 pwm_i SHALL be registered as (en AND us_cnt < width_i), so pwm_i reflects the counter state one clock later.
REQ-017 With CLK_HZ=1000000, pwm_i SHALL be high exactly width_i consecutive cycles per frame.
REQ-018 width_i ≥ PERIOD_US SHALL give a continuously high output; width_i = 0 SHALL give a continuously low output.
REQ-019 frame_start SHALL be high for exactly one clock, on the cycle after each frame boundary.
REQ-020 en SHALL gate only the outputs; prescaler, us_cnt, shadow loads and frame_start SHALL continue regardless of en.
REQ-021 en deasserted mid-pulse SHALL drive pwm_i low on the next edge; reasserted mid-frame, pwm_i SHALL resume per REQ-016 without restarting the frame.

Reset
REQ-022 While rst is high: prescaler, us_cnt, pwm1..pwm4 and frame_start SHALL be 0 immediately, independent of clk.
REQ-023 While rst is high, shadow widths SHALL be the 90-degree value (1500 at defaults), matching the centred position.
REQ-024 Assertion mid-pulse SHALL drop pwm outputs within the same cycle; after release the first frame SHALL start at us_cnt 0 using the 90-degree widths.

Configuration
REQ-025 Macro SERVO_PWM_CLAMP_EN defined: angle_i > 180 SHALL be clamped to 180 before the REQ-014 computation.
REQ-026 Macro SERVO_PWM_CLAMP_EN undefined: angle_i SHALL be used unmodified, so angle 255 yields a width of MIN_US + 255*(MAX_US-MIN_US)/180.

Verification (CLK_HZ=1000000, other parameters at default)
REQ-027 Bench SHALL cover: rst pulse, en=1, all angles 0 -> first frame pwm1..4 high for 1500 cycles, all later frames high for 1000 cycles, frame_start every 20000 cycles.
REQ-028 Bench SHALL cover: angle1=180, angle2=45 loaded before a boundary -> pwm1 high 2000 cycles, pwm2 high 1250 cycles in the next frame.
REQ-029 Bench SHALL cover: angle3 changed 0->180 at us_cnt=500 -> current frame pwm3 width unchanged at 1000, next frame 2000.
REQ-030 Bench SHALL cover: angle4=200 -> pwm4 width 2000 with SERVO_PWM_CLAMP_EN defined, 2111 without.
REQ-031 Bench SHALL cover: en dropped at us_cnt=300 for 100 cycles -> all pwm low within one cycle; frame_start period stays 20000.
REQ-032 Bench SHALL cover: rst asserted between clock edges at us_cnt=700 -> pwm and frame_start go to 0 before the next edge; after release, pwm widths are 1500.

Source files
------------

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: four-channel 50 Hz servo PWM with per-frame shadowed pulse widths.
// Define SERVO_PWM_CLAMP_EN to clamp angles above 180 degrees before width conversion.
module servo_pwm_gen #(
  parameter int CLK_HZ    = 50000000,
  parameter int PERIOD_US = 20000,
  parameter int MIN_US    = 1000,
  parameter int MAX_US    = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] angle1,
  input  logic [7:0] angle2,
  input  logic [7:0] angle3,
  input  logic [7:0] angle4,
  output logic       pwm1,
  output logic       pwm2,
  output logic       pwm3,
  output logic       pwm4,
  output logic       frame_start
);
  localparam int DIV = CLK_HZ / 1000000;
  localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int CW  = PERIOD_US > 1 ? $clog2(PERIOD_US) : 1;
  logic [PW-1:0] pre;
  logic [CW-1:0] us_cnt;
  logic [31:0]   width [4];
  logic [7:0]    ang [4];
  logic          tick, boundary;
  function automatic logic [31:0] calc(input logic [7:0] a);
    logic [7:0] c;
`ifdef SERVO_PWM_CLAMP_EN
    c = a > 8'd180 ? 8'd180 : a;
`else
    c = a;
`endif
    return 32'(MIN_US) + (32'(c) * 32'(MAX_US - MIN_US)) / 32'd180;
  endfunction
  assign ang      = '{angle1, angle2, angle3, angle4};
  assign tick     = pre == PW'(DIV - 1);
  assign boundary = tick && us_cnt == CW'(PERIOD_US - 1);
  // Widths reset to the centred position so the first frame after reset is neutral.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre         <= '0;
      us_cnt      <= '0;
      frame_start <= 1'b0;
      pwm1        <= 1'b0;
      pwm2        <= 1'b0;
      pwm3        <= 1'b0;
      pwm4        <= 1'b0;
      for (int i = 0; i < 4; i++) width[i] <= calc(8'd90);
    end else begin
      pre         <= tick ? '0 : pre + 1'b1;
      if (tick) us_cnt <= boundary ? '0 : us_cnt + 1'b1;
      frame_start <= boundary;
      if (boundary) for (int i = 0; i < 4; i++) width[i] <= calc(ang[i]);
      pwm1        <= en && 32'(us_cnt) < width[0];
      pwm2        <= en && 32'(us_cnt) < width[1];
      pwm3        <= en && 32'(us_cnt) < width[2];
      pwm4        <= en && 32'(us_cnt) < width[3];
    end
  end
endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen: directed frame-by-frame checks of servo_pwm_gen at CLK_HZ=1MHz.
module tb_servo_pwm_gen;
  logic       clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic [7:0] angle1 = 8'd0, angle2 = 8'd0, angle3 = 8'd0, angle4 = 8'd0;
  logic       pwm1, pwm2, pwm3, pwm4, frame_start;
  logic [3:0] pv;
  int         cyc, fs_n, fs_last, fs_period, total, fails;
  int         cnt [4];
  servo_pwm_gen #(.CLK_HZ(1000000)) dut (
    .clk(clk), .rst(rst), .en(en),
    .angle1(angle1), .angle2(angle2), .angle3(angle3), .angle4(angle4),
    .pwm1(pwm1), .pwm2(pwm2), .pwm3(pwm3), .pwm4(pwm4),
    .frame_start(frame_start)
  );
  assign pv = {pwm4, pwm3, pwm2, pwm1};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic clr();
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    fs_n = 0;
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 4; k++) cnt[k] += int'(pv[k]);
      if (frame_start) begin
        fs_n++;
        fs_period = cyc - fs_last;
        fs_last   = cyc;
      end
    end
  endtask
  initial begin
    int exp4;
`ifdef SERVO_PWM_CLAMP_EN
    exp4 = 2000;
`else
    exp4 = 2111;
`endif
    total = 0; fails = 0; cyc = 0; fs_last = 0; fs_period = 0;
    clr();
    repeat (3) @(negedge clk);
    chk("reset_pwm", int'(pv), 0);
    chk("reset_fs", int'(frame_start), 0);
    rst = 1'b0;
    // Frame A: centred widths from reset.
    step(20000);
    chk("fa_pwm1", cnt[0], 1500);
    chk("fa_pwm2", cnt[1], 1500);
    chk("fa_pwm3", cnt[2], 1500);
    chk("fa_pwm4", cnt[3], 1500);
    chk("fa_fs_count", fs_n, 1);
    chk("fa_fs_cycle", fs_last, 20000);
    // Frame B: angle 0 widths; new angles mid-frame must not take effect yet.
    clr();
    step(500);
    angle1 = 8'd180; angle2 = 8'd45; angle3 = 8'd180; angle4 = 8'd200;
    step(19500);
    chk("fb_pwm1", cnt[0], 1000);
    chk("fb_pwm2", cnt[1], 1000);
    chk("fb_pwm3", cnt[2], 1000);
    chk("fb_pwm4", cnt[3], 1000);
    chk("fb_fs_count", fs_n, 1);
    chk("fb_fs_period", fs_period, 20000);
    // Frame C: new widths, en low for 100 cycles starting at us_cnt 300.
    clr();
    step(300);
    en = 1'b0;
    step(1);
    chk("fc_en_off", int'(pv), 0);
    step(99);
    en = 1'b1;
    step(19600);
    chk("fc_pwm1", cnt[0], 1900);
    chk("fc_pwm2", cnt[1], 1150);
    chk("fc_pwm3", cnt[2], 1900);
    chk("fc_pwm4", cnt[3], exp4 - 100);
    chk("fc_fs_count", fs_n, 1);
    chk("fc_fs_period", fs_period, 20000);
    // Frame D: async reset between edges at us_cnt 700.
    clr();
    step(700);
    chk("fd_pre_rst_pwm", int'(pv), 15);
    #2 rst = 1'b1;
    #1;
    chk("fd_rst_pwm", int'(pv), 0);
    chk("fd_rst_fs", int'(frame_start), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clr();
    step(1);
    chk("fd_first_pwm", int'(pv), 15);
    step(1999);
    chk("fd_pwm1", cnt[0], 1500);
    chk("fd_pwm2", cnt[1], 1500);
    chk("fd_pwm3", cnt[2], 1500);
    chk("fd_pwm4", cnt[3], 1500);
    chk("fd_fs_count", fs_n, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
